// File: rtl/bcd_pkg.sv
// Packed-BCD price type shared by the order-book blocks.
// Four BCD digits; BCD encoding is monotonic, so plain unsigned compares order prices.
package bcd_pkg;

    localparam int PRICE_DIGITS = 4;
    localparam int PRICE_W      = 4 * PRICE_DIGITS;

    typedef logic [PRICE_W-1:0] price_t;

    localparam price_t PRICE_MAX = 16'h9999;
    localparam price_t PRICE_MIN = 16'h0000;

endpackage

// File: rtl/ob_pkg.sv
// Order-book table types: entries, commands, events and cell shift selects.
// Helpers: price ordering per side and the empty-entry value per side.
package ob_pkg;

    import bcd_pkg::*;

    localparam int UID_W = 8;
    localparam int QTY_W = 16;

    typedef logic [UID_W-1:0] uid_t;
    typedef logic [QTY_W-1:0] qty_t;

    typedef struct packed {
        uid_t            uid;
        qty_t            qty;
        bcd_pkg::price_t price;
    } table_t;

    typedef enum logic [1:0] {
        OP_INSTALL = 2'd0,
        OP_POP     = 2'd1,
        OP_FILL    = 2'd2,
        OP_CANCEL  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        EVT_REMOVED     = 2'd0,
        EVT_CANCEL_HIT  = 2'd1,
        EVT_CANCEL_MISS = 2'd2,
        EVT_ERR         = 2'd3
    } evt_code_t;

    typedef struct packed {
        evt_code_t code;
        uid_t      uid;
    } evt_t;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_LOAD  = 2'd1,
        SEL_LOWER = 2'd2,
        SEL_UPPER = 2'd3
    } sel_t;

    // Strictly better: lower price on the ask side, higher on the bid side.
    function automatic logic price_better(input logic is_ask, input price_t a, input price_t b);
        return is_ask ? (a < b) : (a > b);
    endfunction

    function automatic table_t empty_entry(input logic is_ask);
        table_t e;
        e.uid   = '0;
        e.qty   = '0;
        e.price = is_ask ? PRICE_MAX : PRICE_MIN;
        return e;
    endfunction

endpackage

// File: rtl/ob_sorted_table_cell.sv
// One table slot: entry register plus valid bit, updated from a parent-computed select.
module ob_sorted_table_cell
    import ob_pkg::*;
#(
    parameter table_t RST_ENTRY = '0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  sel_t   sel,
    input  table_t load_entry,
    input  logic   lower_vld,
    input  table_t lower_entry,
    input  logic   upper_vld,
    input  table_t upper_entry,
    output logic   vld_r,
    output table_t entry_r
);

    // Slot register: hold, load the new entry, or shift in from a neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r   <= 1'b0;
            entry_r <= RST_ENTRY;
        end else begin
            case (sel)
                SEL_LOAD: begin
                    vld_r   <= 1'b1;
                    entry_r <= load_entry;
                end
                SEL_LOWER: begin
                    vld_r   <= lower_vld;
                    entry_r <= lower_entry;
                end
                SEL_UPPER: begin
                    vld_r   <= upper_vld;
                    entry_r <= upper_entry;
                end
                default: begin
                    vld_r   <= vld_r;
                    entry_r <= entry_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/ob_sorted_table.sv
// Price/time-priority order table with a one-entry reject slot.
// Optional uid cancel logic is built when OB_SORTED_TABLE_CANCEL_EN is defined.
module ob_sorted_table
    import ob_pkg::*;
#(
    parameter int N      = 16,
    parameter bit IS_ASK = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    input  op_t                    cmd_op,
    input  table_t                 cmd_entry,
    output logic                   head_vld_r,
    output table_t                 head_r,
    output logic [$clog2(N+1)-1:0] count_r,
    input  logic                   reject_pop,
    output logic                   reject_vld_r,
    output table_t                 reject_r,
    output logic                   evt_vld_r,
    output evt_t                   evt_r
);

    localparam int     CW        = $clog2(N + 1);
    localparam int     IW        = $clog2(N);
    localparam table_t RST_ENTRY = empty_entry(IS_ASK);

    table_t          ent_s [N];
    logic   [N-1:0]  vld_s;
    sel_t            sel_s [N];
    logic   [N-1:0]  better_s;
    logic   [IW-1:0] ins_pos_s;
    logic            ins_hit_s;
    logic            ins_en_s;
    logic            rm_en_s;
    logic   [IW-1:0] rm_pos_s;
    table_t          load_entry_s;
    logic   [CW-1:0] count_nxt_s;
    logic            rej_load_s;
    table_t          rej_entry_s;
    logic            evt_vld_nxt_s;
    evt_t            evt_nxt_s;
    logic            accept_s;
    logic            full_s;
    logic            empty_s;
    qty_t            head_qty_s;

`ifdef OB_SORTED_TABLE_CANCEL_EN
    logic   [N-1:0]  match_s;
    logic   [IW-1:0] cancel_pos_s;
    logic            cancel_hit_s;
`endif

    for (genvar g = 0; g < N; g++) begin : g_cell
        table_t lower_entry_s;
        table_t upper_entry_s;
        logic   lower_vld_s;
        logic   upper_vld_s;

        if (g == 0) begin : g_bottom
            assign lower_entry_s = RST_ENTRY;
            assign lower_vld_s   = 1'b0;
        end else begin : g_lower
            assign lower_entry_s = ent_s[g-1];
            assign lower_vld_s   = vld_s[g-1];
        end

        if (g == N - 1) begin : g_top
            assign upper_entry_s = RST_ENTRY;
            assign upper_vld_s   = 1'b0;
        end else begin : g_upper
            assign upper_entry_s = ent_s[g+1];
            assign upper_vld_s   = vld_s[g+1];
        end

        // Invalid slots always accept, so a non-full table always finds a position.
        assign better_s[g] = !vld_s[g] || price_better(IS_ASK, cmd_entry.price, ent_s[g].price);

`ifdef OB_SORTED_TABLE_CANCEL_EN
        assign match_s[g] = vld_s[g] && (ent_s[g].uid == cmd_entry.uid);
`endif

        ob_sorted_table_cell #(
            .RST_ENTRY (RST_ENTRY)
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .sel         (sel_s[g]),
            .load_entry  (load_entry_s),
            .lower_vld   (lower_vld_s),
            .lower_entry (lower_entry_s),
            .upper_vld   (upper_vld_s),
            .upper_entry (upper_entry_s),
            .vld_r       (vld_s[g]),
            .entry_r     (ent_s[g])
        );
    end

    assign head_r     = ent_s[0];
    assign head_vld_r = vld_s[0];
    assign head_qty_s = ent_s[0].qty;
    assign full_s     = (count_r == CW'(N));
    assign empty_s    = !vld_s[0];
    assign cmd_rdy    = !(reject_vld_r && full_s);
    assign accept_s   = cmd_vld && cmd_rdy;
    assign ins_hit_s  = |better_s;

    // First-one detect on the insert compares; scanning downward lets the lowest index win.
    always_comb begin
        ins_pos_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            ins_pos_s = better_s[i] ? IW'(i) : ins_pos_s;
        end
    end

`ifdef OB_SORTED_TABLE_CANCEL_EN
    assign cancel_hit_s = |match_s;

    // First-one detect on the uid matches.
    always_comb begin
        cancel_pos_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cancel_pos_s = match_s[i] ? IW'(i) : cancel_pos_s;
        end
    end
`endif

    // Command decode: per-slot shift selects, next count, reject load and event.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            sel_s[i] = SEL_HOLD;
        end
        load_entry_s   = cmd_entry;
        count_nxt_s    = count_r;
        rej_load_s     = 1'b0;
        rej_entry_s    = cmd_entry;
        ins_en_s       = 1'b0;
        rm_en_s        = 1'b0;
        rm_pos_s       = '0;
        evt_vld_nxt_s  = 1'b0;
        evt_nxt_s.code = EVT_ERR;
        evt_nxt_s.uid  = cmd_entry.uid;

        if (accept_s) begin
            case (cmd_op)
                OP_INSTALL: begin
                    if (full_s) begin
                        rej_load_s    = 1'b1;
                        evt_vld_nxt_s = 1'b1;
                        if (ins_hit_s) begin
                            ins_en_s    = 1'b1;
                            rej_entry_s = ent_s[N-1];
                        end else begin
                            rej_entry_s = cmd_entry;
                        end
                        evt_nxt_s.code = EVT_REMOVED;
                        evt_nxt_s.uid  = rej_entry_s.uid;
                    end else begin
                        ins_en_s    = 1'b1;
                        count_nxt_s = count_r + CW'(1);
                    end
                end
                OP_POP: begin
                    evt_vld_nxt_s = 1'b1;
                    if (empty_s) begin
                        evt_nxt_s.code = EVT_ERR;
                    end else begin
                        rm_en_s        = 1'b1;
                        count_nxt_s    = count_r - CW'(1);
                        evt_nxt_s.code = EVT_REMOVED;
                        evt_nxt_s.uid  = ent_s[0].uid;
                    end
                end
                OP_FILL: begin
                    if (empty_s) begin
                        evt_vld_nxt_s  = 1'b1;
                        evt_nxt_s.code = EVT_ERR;
                    end else if (cmd_entry.qty >= head_qty_s) begin
                        // Exact fill removes cleanly; an overfill still removes the head but flags it.
                        rm_en_s        = 1'b1;
                        count_nxt_s    = count_r - CW'(1);
                        evt_vld_nxt_s  = 1'b1;
                        evt_nxt_s.code = (cmd_entry.qty == head_qty_s) ? EVT_REMOVED : EVT_ERR;
                        evt_nxt_s.uid  = ent_s[0].uid;
                    end else begin
                        load_entry_s     = ent_s[0];
                        load_entry_s.qty = head_qty_s - cmd_entry.qty;
                        sel_s[0]         = SEL_LOAD;
                    end
                end
                OP_CANCEL: begin
                    evt_vld_nxt_s = 1'b1;
`ifdef OB_SORTED_TABLE_CANCEL_EN
                    if (cancel_hit_s) begin
                        rm_en_s        = 1'b1;
                        rm_pos_s       = cancel_pos_s;
                        count_nxt_s    = count_r - CW'(1);
                        evt_nxt_s.code = EVT_CANCEL_HIT;
                    end else begin
                        evt_nxt_s.code = EVT_CANCEL_MISS;
                    end
`else
                    evt_nxt_s.code = EVT_ERR;
`endif
                end
                default: begin
                    evt_vld_nxt_s = 1'b0;
                end
            endcase
        end else begin
            evt_vld_nxt_s = 1'b0;
        end

        for (int i = 0; i < N; i++) begin
            if (ins_en_s && (IW'(i) > ins_pos_s)) begin
                sel_s[i] = SEL_LOWER;
            end else if (ins_en_s && (IW'(i) == ins_pos_s)) begin
                sel_s[i] = SEL_LOAD;
            end else if (rm_en_s && (IW'(i) >= rm_pos_s)) begin
                sel_s[i] = SEL_UPPER;
            end else begin
                sel_s[i] = sel_s[i];
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    // Reject slot: an overflow load wins over a simultaneous pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reject_vld_r <= 1'b0;
            reject_r     <= RST_ENTRY;
        end else if (rej_load_s) begin
            reject_vld_r <= 1'b1;
            reject_r     <= rej_entry_s;
        end else if (reject_pop) begin
            reject_vld_r <= 1'b0;
        end
    end

    // Single-cycle event pulse; the payload holds until the next event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_vld_r <= 1'b0;
            evt_r     <= '0;
        end else begin
            evt_vld_r <= evt_vld_nxt_s;
            if (evt_vld_nxt_s) begin
                evt_r <= evt_nxt_s;
            end
        end
    end

endmodule
